// File: rtl/sha256_sys_pkg.sv
// Shared types and constants for the SHA-256 host-side message server.
// Holds the FSM state enum, the window bases and the address-window hit test.
package sha256_sys_pkg;

    typedef enum logic [2:0] {
        LOAD,
        KICK,
        WAIT_ACK,
        RUN,
        OUTPUT
    } state_t;

    localparam int          HASH_WORDS      = 8;
    localparam logic [15:0] DEF_INPUT_ADDR  = 16'h0000;
    localparam logic [15:0] DEF_HASH_ADDR   = 16'h0100;

    // Compares in 17 bits so a window ending at 16'hFFFF cannot wrap to zero.
    function automatic logic in_window(input logic [15:0] addr,
                                       input logic [15:0] base,
                                       input logic [16:0] len);
        logic [16:0] a;
        logic [16:0] b;
        a = {1'b0, addr};
        b = {1'b0, base};
        return (a >= b) && (a < (b + len));
    endfunction

endpackage

// File: rtl/sha256_word_ram.sv
// Message word store: one write port, one synchronous read port with a
// registered output that clears on reset.
module sha256_word_ram #(
    parameter int DEPTH = 40,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sha256_msg_server.sv
// Loads a message from the host, kicks the SHA-256 engine, serves its memory
// reads, captures its 8 hash writes and hands them back as one digest.
module sha256_msg_server
    import sha256_sys_pkg::*;
#(
    parameter int          NUM_OF_WORDS = 40,
    parameter logic [15:0] INPUT_ADDR   = DEF_INPUT_ADDR,
    parameter logic [15:0] HASH_ADDR    = DEF_HASH_ADDR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         msg_valid,
    input  logic [31:0]  msg_data,
    output logic         msg_ready,
    output logic         digest_valid,
    output logic [255:0] digest,
    input  logic         digest_ready,
    output logic         busy,
    output logic         err,
    output logic         eng_start,
    input  logic         eng_done,
    output logic [15:0]  eng_input_addr,
    output logic [15:0]  eng_hash_addr,
    input  logic [15:0]  eng_addr,
    input  logic         eng_we,
    input  logic [31:0]  eng_wdata,
    output logic [31:0]  eng_rdata
);

    localparam int CW = $clog2(NUM_OF_WORDS + 1);
    localparam int AW = (NUM_OF_WORDS > 1) ? $clog2(NUM_OF_WORDS) : 1;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [7:0]      mask;
    logic [7:0]      mask_nxt;
    logic [31:0]     hash [HASH_WORDS];
    logic            hit_q;
    logic [31:0]     ram_rdata;
    logic            accept;
    logic            rd_hit;
    logic            hash_hit;
    logic            hash_we;
    logic            bad_we;
    logic [15:0]     rd_off;
    logic [15:0]     hash_off;
    logic [2:0]      hash_idx;
    logic [AW-1:0]   ram_raddr;

    assign eng_input_addr = INPUT_ADDR;
    assign eng_hash_addr  = HASH_ADDR;

    assign accept    = msg_valid & msg_ready;
    assign rd_hit    = in_window(eng_addr, INPUT_ADDR, 17'(NUM_OF_WORDS));
    assign hash_hit  = in_window(eng_addr, HASH_ADDR, 17'(HASH_WORDS));
    assign rd_off    = eng_addr - INPUT_ADDR;
    assign hash_off  = eng_addr - HASH_ADDR;
    assign hash_idx  = hash_off[2:0];
    assign ram_raddr = rd_hit ? rd_off[AW-1:0] : '0;

    // Hash writes are frozen while the digest is on offer so it stays stable.
    assign hash_we = eng_we & hash_hit & (state != OUTPUT);
    assign bad_we  = eng_we & ~hash_hit;

    always_comb begin
        mask_nxt = mask;
        if (state == LOAD) begin
            mask_nxt = '0;
        end else if (hash_we) begin
            mask_nxt = mask | (8'b1 << hash_idx);
        end
    end

    always_comb begin
        state_nxt    = state;
        msg_ready    = 1'b0;
        eng_start    = 1'b0;
        busy         = 1'b0;
        digest_valid = 1'b0;
        case (state)
            LOAD: begin
                msg_ready = ~rst;
                if (accept && cnt == CW'(NUM_OF_WORDS - 1)) begin
                    state_nxt = KICK;
                end
            end
            KICK: begin
                eng_start = 1'b1;
                busy      = 1'b1;
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                eng_start = 1'b1;
                busy      = 1'b1;
                if (!eng_done) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (eng_done) begin
                    state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                digest_valid = 1'b1;
                if (digest_ready) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
            cnt   <= '0;
            mask  <= '0;
            err   <= 1'b0;
            hit_q <= 1'b0;
            for (int k = 0; k < HASH_WORDS; k++) begin
                hash[k] <= '0;
            end
        end else begin
            state <= state_nxt;
            mask  <= mask_nxt;
            hit_q <= rd_hit;
            if (accept) begin
                cnt <= cnt + 1'b1;
            end else if (state == OUTPUT && digest_ready) begin
                cnt <= '0;
            end
            if (hash_we) begin
                hash[hash_idx] <= eng_wdata;
            end
            // A missing hash word is flagged as the digest is presented.
            if (bad_we || (state == RUN && eng_done && mask_nxt != 8'hFF)) begin
                err <= 1'b1;
            end
        end
    end

    sha256_word_ram #(
        .DEPTH (NUM_OF_WORDS)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (accept),
        .waddr (cnt[AW-1:0]),
        .wdata (msg_data),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign eng_rdata = hit_q ? ram_rdata : 32'h0;

    always_comb begin
        digest = '0;
        for (int k = 0; k < HASH_WORDS; k++) begin
            digest[255 - 32*k -: 32] = hash[k];
        end
    end

endmodule

// File: tb/tb_sha256_msg_server.sv
// Randomized bench for sha256_msg_server: a host and engine model drive jobs
// and a word-level reference of message, hash words and error flag checks them.
module tb_sha256_msg_server;

    localparam int          N  = 40;
    localparam logic [15:0] IA = 16'h0000;
    localparam logic [15:0] HA = 16'h0100;

    logic         clk;
    logic         rst;
    logic         msg_valid;
    logic [31:0]  msg_data;
    logic         msg_ready;
    logic         digest_valid;
    logic [255:0] digest;
    logic         digest_ready;
    logic         busy;
    logic         err;
    logic         eng_start;
    logic         eng_done;
    logic [15:0]  eng_input_addr;
    logic [15:0]  eng_hash_addr;
    logic [15:0]  eng_addr;
    logic         eng_we;
    logic [31:0]  eng_wdata;
    logic [31:0]  eng_rdata;

    int tests_run;
    int tests_failed;

    logic [31:0] msg_model  [N];
    logic [31:0] hash_model [8];
    logic        err_model;

    sha256_msg_server #(
        .NUM_OF_WORDS (N),
        .INPUT_ADDR   (IA),
        .HASH_ADDR    (HA)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .msg_valid      (msg_valid),
        .msg_data       (msg_data),
        .msg_ready      (msg_ready),
        .digest_valid   (digest_valid),
        .digest         (digest),
        .digest_ready   (digest_ready),
        .busy           (busy),
        .err            (err),
        .eng_start      (eng_start),
        .eng_done       (eng_done),
        .eng_input_addr (eng_input_addr),
        .eng_hash_addr  (eng_hash_addr),
        .eng_addr       (eng_addr),
        .eng_we         (eng_we),
        .eng_wdata      (eng_wdata),
        .eng_rdata      (eng_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] model_digest();
        logic [255:0] d;
        for (int k = 0; k < 8; k++) begin
            d[255 - 32*k -: 32] = hash_model[k];
        end
        return d;
    endfunction

    task automatic idle_inputs();
        msg_valid    = 1'b0;
        msg_data     = '0;
        digest_ready = 1'b0;
        eng_we       = 1'b0;
        eng_addr     = '0;
        eng_wdata    = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        eng_done = 1'b1;
        @(negedge clk);
        checkOutput("rst_msg_ready", 256'(msg_ready), 256'(0));
        checkOutput("rst_eng_start", 256'(eng_start), 256'(0));
        checkOutput("rst_digest_valid", 256'(digest_valid), 256'(0));
        checkOutput("rst_busy", 256'(busy), 256'(0));
        checkOutput("rst_err", 256'(err), 256'(0));
        checkOutput("rst_eng_rdata", 256'(eng_rdata), 256'(0));
        checkOutput("rst_digest", digest, 256'(0));
        rst = 1'b0;
        for (int k = 0; k < 8; k++) hash_model[k] = '0;
        err_model = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_msg_ready", 256'(msg_ready), 256'(1));
        checkOutput("post_rst_const_addr", {eng_input_addr, eng_hash_addr}, {IA, HA});
    endtask

    // Host side: pushes count words with random idle gaps.
    task automatic load_words(input int count, input bit use_index);
        for (int i = 0; i < count; i++) begin
            while ($urandom_range(0, 2) == 0) begin
                msg_valid = 1'b0;
                msg_data  = $urandom;
                @(negedge clk);
            end
            msg_data     = use_index ? 32'(i) : $urandom;
            msg_model[i] = msg_data;
            checkOutput("load_msg_ready", 256'(msg_ready), 256'(1));
            msg_valid = 1'b1;
            @(negedge clk);
        end
        msg_valid = 1'b0;
        if (count == N) begin
            checkOutput("kick_eng_start", 256'(eng_start), 256'(1));
            checkOutput("kick_busy", 256'(busy), 256'(1));
            checkOutput("kick_msg_ready", 256'(msg_ready), 256'(0));
        end
    endtask

    task automatic check_read(input logic [15:0] addr);
        logic [31:0] exp;
        eng_we   = 1'b0;
        eng_addr = addr;
        exp = (addr >= IA && {1'b0, addr} < {1'b0, IA} + 17'(N)) ? msg_model[addr - IA] : 32'h0;
        @(negedge clk);
        checkOutput($sformatf("read_%0h", addr), 256'(eng_rdata), 256'(exp));
    endtask

    // Engine side: handshake on start, then a batch of reads.
    task automatic engine_begin();
        eng_done  = 1'b1;
        msg_valid = 1'b1;
        msg_data  = $urandom;
        repeat (2) begin
            @(negedge clk);
            checkOutput("ack_eng_start_held", 256'(eng_start), 256'(1));
            checkOutput("ack_msg_ready", 256'(msg_ready), 256'(0));
        end
        msg_valid = 1'b0;
        eng_done  = 1'b0;
        @(negedge clk);
        checkOutput("run_eng_start", 256'(eng_start), 256'(0));
        checkOutput("run_busy", 256'(busy), 256'(1));
        check_read(IA + 16'd5);
        check_read(IA + 16'd45);
        check_read(16'hFFFF);
        check_read(IA + 16'(N - 1));
        check_read(IA + 16'(N));
        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 1) == 1) check_read(IA + 16'($urandom_range(0, N - 1)));
            else check_read(16'($urandom_range(N, 16'hFFFF)));
        end
    endtask

    task automatic hash_write(input logic [15:0] addr, input logic [31:0] data);
        eng_we    = 1'b1;
        eng_addr  = addr;
        eng_wdata = data;
        if (addr >= HA && addr < HA + 16'd8) hash_model[addr - HA] = data;
        else err_model = 1'b1;
        @(negedge clk);
        checkOutput("write_cycle_rdata", 256'(eng_rdata),
                    256'((addr >= IA && {1'b0, addr} < {1'b0, IA} + 17'(N)) ? msg_model[addr - IA] : 32'h0));
    endtask

    // Engine writes the hash (optionally skipping word 3), then goes idle.
    task automatic engine_finish(input bit fixed_data, input bit omit3, input bit bad_write);
        bit written [8];
        bit all_written;
        for (int k = 0; k < 8; k++) written[k] = 1'b0;
        if (!omit3) begin
            hash_write(HA, $urandom);
            written[0] = 1'b1;
        end
        for (int k = 0; k < 8; k++) begin
            if (omit3 && k == 3) continue;
            hash_write(HA + 16'(k), fixed_data ? 32'(32'h11111111 * (k + 1)) : $urandom);
            written[k] = 1'b1;
        end
        if (bad_write) hash_write(IA, $urandom);
        eng_we   = 1'b0;
        eng_addr = '0;
        checkOutput("pre_done_digest_valid", 256'(digest_valid), 256'(0));
        eng_done = 1'b1;
        all_written = 1'b1;
        for (int k = 0; k < 8; k++) if (!written[k]) all_written = 1'b0;
        if (!all_written) err_model = 1'b1;
        @(negedge clk);
        checkOutput("out_digest_valid", 256'(digest_valid), 256'(1));
        checkOutput("out_digest", digest, model_digest());
        checkOutput("out_err", 256'(err), 256'(err_model));
        checkOutput("out_busy", 256'(busy), 256'(0));
    endtask

    task automatic drain_digest(input int hold);
        logic [255:0] exp;
        exp = model_digest();
        digest_ready = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            checkOutput("hold_digest", digest, exp);
            checkOutput("hold_digest_valid", 256'(digest_valid), 256'(1));
            checkOutput("hold_msg_ready", 256'(msg_ready), 256'(0));
        end
        digest_ready = 1'b1;
        @(negedge clk);
        digest_ready = 1'b0;
        checkOutput("drain_msg_ready", 256'(msg_ready), 256'(1));
        checkOutput("drain_digest_valid", 256'(digest_valid), 256'(0));
        checkOutput("drain_err", 256'(err), 256'(err_model));
    endtask

    task automatic applyStimulus(input bit use_index, input bit fixed_data,
                                 input bit omit3, input bit bad_write, input int hold);
        load_words(N, use_index);
        engine_begin();
        engine_finish(fixed_data, omit3, bad_write);
        drain_digest(hold);
    endtask

    task automatic check_after_abort(input string tag);
        checkOutput({tag, "_eng_start"}, 256'(eng_start), 256'(0));
        checkOutput({tag, "_digest_valid"}, 256'(digest_valid), 256'(0));
        checkOutput({tag, "_msg_ready"}, 256'(msg_ready), 256'(1));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        eng_done     = 1'b1;
        idle_inputs();
        err_model    = 1'b0;
        for (int k = 0; k < 8; k++) hash_model[k] = '0;

        do_reset();

        digest_ready = 1'b1;
        @(negedge clk);
        digest_ready = 1'b0;
        checkOutput("stray_ready_msg_ready", 256'(msg_ready), 256'(1));
        checkOutput("stray_ready_digest_valid", 256'(digest_valid), 256'(0));

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);

        do_reset();
        load_words(20, 1'b0);
        do_reset();
        check_after_abort("abort_load");

        load_words(N, 1'b0);
        engine_begin();
        do_reset();
        check_after_abort("abort_run");

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sha256_msg_server.md
# sha256_msg_server

Host-side counterpart of the SHA-256 engine's memory port. Accepts a message as a valid/ready word stream, stores it in internal RAM, pulses the engine's `start`, and serves the engine's word-addressed reads. It captures the 8 hash words the engine writes back and presents them as one 256-bit digest with a valid/ready handshake. It sits between the system host bus and the hash engine, replacing a shared external memory.

## Interface
- `NUM_OF_WORDS`, 40: message length in 32-bit words per job; must match the engine.
- `INPUT_ADDR`, 16'h0000: base of the message window.
- `HASH_ADDR`, 16'h0100: base of the 8-word hash window; must not overlap `[INPUT_ADDR, INPUT_ADDR+NUM_OF_WORDS)`.
- `clk`  in  1  single clock, all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `msg_valid`  in  1  host message word valid.
- `msg_data`  in  32  host message word.
- `msg_ready`  out  1  block accepts a message word.
- `digest_valid`  out  1  digest available.
- `digest`  out  256  hash; `[255:224]` is the word at `HASH_ADDR`, `[31:0]` is the word at `HASH_ADDR+7`.
- `digest_ready`  in  1  host consumes the digest.
- `busy`  out  1  a job is in flight (states KICK, WAIT_ACK, RUN).
- `err`  out  1  sticky protocol error flag.
- `eng_start`  out  1  start request to the engine.
- `eng_done`  in  1  engine idle indicator (high while the engine is idle).
- `eng_input_addr`, `eng_hash_addr`  out  16  constant `INPUT_ADDR` / `HASH_ADDR`.
- `eng_addr`  in  16  engine memory address.
- `eng_we`  in  1  engine write enable.
- `eng_wdata`  in  32  engine write data.
- `eng_rdata`  out  32  read data returned to the engine.

## Operation
- States: LOAD → KICK → WAIT_ACK → RUN → OUTPUT → LOAD. The reset state is LOAD.
- LOAD
  - `msg_ready = (state==LOAD) & ~rst`.
  - Each handshake writes `ram[cnt] <= msg_data` and increments `cnt`.
  - The accept with `cnt==NUM_OF_WORDS-1` goes to KICK.
  - Clearing the hash-write mask happens here.
- KICK: `eng_start=1`; go to WAIT_ACK.
- WAIT_ACK
  - `eng_start` stays 1 until `eng_done==0` is sampled.
  - That cycle drops `eng_start` and goes to RUN.
- RUN: serve reads and writes. On `eng_done==1`, go to OUTPUT.
- OUTPUT
  - `digest_valid=1`; digest is held stable.
  - On `digest_ready`, go to LOAD and set `cnt=0`.
- Reads (every state)
  - `eng_rdata <= ram[eng_addr-INPUT_ADDR]` when `eng_addr` is inside the message window.
  - Otherwise `eng_rdata <= 0`. Out-of-window reads are legal; they cover the engine's padding reads past the message.
- Writes
  - When `eng_we=1` and `eng_addr` is in `[HASH_ADDR, HASH_ADDR+7]`, set `hash[k] <= eng_wdata` and `mask[k] <= 1`.
  - Repeated writes to the same word: the last one wins.
  - A write to any other address is dropped and sets `err`.
- `err` is also set on entry to OUTPUT if `mask != 8'hFF`. The digest is still presented.
- `err` clears only on `rst`.
- Width rules
  - Window checks use 17-bit unsigned compares, so no wrap at 16'hFFFF.
  - `cnt` is `$clog2(NUM_OF_WORDS+1)` bits.

## Timing
- Reset values: `msg_ready` 0 while `rst` is high and 1 after release; all other outputs 0; `eng_rdata` 0.
- The handshake is accepted when valid & ready are both high at the posedge.
- `eng_start` rises on the cycle after the final message accept.
- Read latency is exactly 1 cycle: the address sampled at edge N gives `eng_rdata` valid after edge N, used by the engine at edge N+1.
- The write is captured at the same edge `eng_we` is sampled.
- `digest_valid` rises 1 cycle after `eng_done` is sampled high in RUN.
- After the `digest_ready` accept, `msg_ready` is 1 on the next cycle. `digest_ready` while `digest_valid` is 0 is ignored.
- A read and a write in the same cycle are both serviced.
- `msg_valid` outside LOAD is ignored; no data is lost because `msg_ready` is 0.
- `rst` mid-job:
  - Immediate return to LOAD; `cnt`, `mask` and `digest_valid` clear.
  - `eng_start` drops and RAM contents are don't-care.
  - The engine must be reset by the system at the same time.

## Structure
- Package `sha256_sys_pkg` holds:
  - the state enum (`LOAD`, `KICK`, `WAIT_ACK`, `RUN`, `OUTPUT`);
  - `HASH_WORDS=8`;
  - the default window base constants;
  - a window-hit function.
- Sub-module `sha256_word_ram`: `NUM_OF_WORDS`×32, one write port and one synchronous read port, registered output. The top level muxes 0 for out-of-window reads.

## Test plan
- Load words 0..39 (`value=index`) with random `msg_valid` gaps → `eng_start` rises the cycle after the 40th accept, stays high until `eng_done` falls, and `busy`=1.
- In RUN, `eng_addr=INPUT_ADDR+5` → `eng_rdata=32'd5` next cycle; `eng_addr=INPUT_ADDR+45` → `eng_rdata=0`.
- Engine model writes `32'h11111111*(k+1)` to `HASH_ADDR+k` for k=0..7, then raises `eng_done` → `digest_valid` one cycle later, `digest[255:224]=32'h11111111`, `digest[31:0]=32'h88888888`, `err=0`.
- Hold `digest_ready=0` for 10 cycles → digest stable and `msg_ready=0`; raise `digest_ready` → `msg_ready=1` on the next cycle, and a second job runs correctly.
- Omit the write to `HASH_ADDR+3` and write once to `INPUT_ADDR` → `err=1`, persisting across the next job until `rst`.
- Assert `rst` after 20 loaded words and again mid-RUN → `eng_start=0`, `digest_valid=0`, `msg_ready=1` after release; a fresh 40-word load completes normally.
